present_dec_wrapper: RTL and testbench



---
 rtl/present_dec_wrapper.sv | 246 ++++++++++++++++++++++++
 tb/tb_present_dec_wrapper.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/present_dec_wrapper.sv
// PRESENT-80 iterative decryption core behind a 32-bit register slave.
// The forward key schedule is replayed first, then rounds are undone one per clock.
module present_dec_wrapper (
  input  logic        clk,
  input  logic        iReset,
  input  logic        iChipselect,
  input  logic        iWriteRead,
  input  logic [3:0]  iAddress,
  input  logic [31:0] idat,
  output logic [31:0] odat
);

  localparam int         ROUNDS   = 31;
  localparam logic [4:0] RC_LAST  = 5'(ROUNDS);
  localparam logic [4:0] RC_FIRST = 5'd1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_WHITEN = 2'd2;
  localparam logic [1:0] ST_ROUND  = 2'd3;

  localparam logic [3:0] A_CT_LO  = 4'h0;
  localparam logic [3:0] A_CT_HI  = 4'h1;
  localparam logic [3:0] A_KEY_LO = 4'h2;
  localparam logic [3:0] A_KEY_MI = 4'h3;
  localparam logic [3:0] A_KEY_HI = 4'h4;
  localparam logic [3:0] A_CTRL   = 4'h5;
  localparam logic [3:0] A_STATUS = 4'h6;
  localparam logic [3:0] A_PT_LO  = 4'h8;
  localparam logic [3:0] A_PT_HI  = 4'h9;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0:    y = 4'hC;
      4'h1:    y = 4'h5;
      4'h2:    y = 4'h6;
      4'h3:    y = 4'hB;
      4'h4:    y = 4'h9;
      4'h5:    y = 4'h0;
      4'h6:    y = 4'hA;
      4'h7:    y = 4'hD;
      4'h8:    y = 4'h3;
      4'h9:    y = 4'hE;
      4'hA:    y = 4'hF;
      4'hB:    y = 4'h8;
      4'hC:    y = 4'h4;
      4'hD:    y = 4'h7;
      4'hE:    y = 4'h1;
      4'hF:    y = 4'h2;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0:    y = 4'h5;
      4'h1:    y = 4'hE;
      4'h2:    y = 4'hF;
      4'h3:    y = 4'h8;
      4'h4:    y = 4'hC;
      4'h5:    y = 4'h1;
      4'h6:    y = 4'h2;
      4'h7:    y = 4'hD;
      4'h8:    y = 4'hB;
      4'h9:    y = 4'h4;
      4'hA:    y = 4'h6;
      4'hB:    y = 4'h3;
      4'hC:    y = 4'h0;
      4'hD:    y = 4'h7;
      4'hE:    y = 4'h9;
      4'hF:    y = 4'hA;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] inv_sbox_layer(input logic [63:0] x);
    logic [63:0] y;
    y = 64'd0;
    for (int n = 0; n < 16; n++) begin
      y[6'(4*n) +: 4] = inv_sbox(x[6'(4*n) +: 4]);
    end
    return y;
  endfunction

  // Output bit j gathers input bit 16*j mod 63; bit 63 is a fixed point.
  function automatic logic [63:0] inv_p(input logic [63:0] x);
    logic [63:0] y;
    y = 64'd0;
    for (int j = 0; j < 63; j++) begin
      y[6'(j)] = x[6'((16*j) % 63)];
    end
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [79:0] fwd_update(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] t;
    t = {k[18:0], k[79:19]};
    t[79:76] = sbox(t[79:76]);
    t[19:15] = t[19:15] ^ rc;
    return t;
  endfunction

  function automatic logic [79:0] inv_update(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] t;
    t = k;
    t[19:15] = t[19:15] ^ rc;
    t[79:76] = inv_sbox(t[79:76]);
    return {t[60:0], t[79:61]};
  endfunction

  logic [63:0] ct_r;
  logic [79:0] key_r;
  logic [63:0] pt_r;
  logic [63:0] s_r;
  logic [79:0] k_r;
  logic [4:0]  rc_r;
  logic [1:0]  state_r;
  logic        busy_r;
  logic        done_r;
  logic [31:0] odat_r;

  logic        wr_s;
  logic        rd_s;
  logic        start_s;
  logic [79:0] k_up_s;
  logic [79:0] k_dn_s;
  logic [63:0] s_dn_s;
  logic [31:0] rd_data_s;

  assign wr_s    = iChipselect & iWriteRead;
  assign rd_s    = iChipselect & ~iWriteRead;
  assign start_s = wr_s & (iAddress == A_CTRL) & idat[0];
  assign odat    = odat_r;

  // Round datapath: forward key step, backward key step and one inverse round.
  always_comb begin
    k_up_s = fwd_update(k_r, rc_r);
    k_dn_s = inv_update(k_r, rc_r);
    s_dn_s = inv_sbox_layer(inv_p(s_r)) ^ k_dn_s[79:16];
  end

  // Host-visible CT/KEY input registers; writes land even while a run is active.
  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset) begin
      ct_r  <= 64'd0;
      key_r <= 80'd0;
    end else if (wr_s) begin
      case (iAddress)
        A_CT_LO:  ct_r[31:0]   <= idat;
        A_CT_HI:  ct_r[63:32]  <= idat;
        A_KEY_LO: key_r[31:0]  <= idat;
        A_KEY_MI: key_r[63:32] <= idat;
        A_KEY_HI: key_r[79:64] <= idat[15:0];
        default:  ;
      endcase
    end
  end

  // Sequencer: expand key to round 32, whiten, then undo rounds 31 down to 1.
  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset) begin
      state_r <= ST_IDLE;
      s_r     <= 64'd0;
      k_r     <= 80'd0;
      rc_r    <= 5'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pt_r    <= 64'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            s_r     <= ct_r;
            k_r     <= key_r;
            rc_r    <= RC_FIRST;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          k_r <= k_up_s;
          if (rc_r == RC_LAST) begin
            state_r <= ST_WHITEN;
          end else begin
            rc_r <= rc_r + 5'd1;
          end
        end
        ST_WHITEN: begin
          s_r     <= s_r ^ k_r[79:16];
          rc_r    <= RC_LAST;
          state_r <= ST_ROUND;
        end
        ST_ROUND: begin
          k_r <= k_dn_s;
          s_r <= s_dn_s;
          if (rc_r == RC_FIRST) begin
            pt_r    <= s_dn_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            rc_r <= rc_r - 5'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Read-data selection for the registered read port.
  always_comb begin
    rd_data_s = 32'd0;
    case (iAddress)
      A_CT_LO:  rd_data_s = ct_r[31:0];
      A_CT_HI:  rd_data_s = ct_r[63:32];
      A_KEY_LO: rd_data_s = key_r[31:0];
      A_KEY_MI: rd_data_s = key_r[63:32];
      A_KEY_HI: rd_data_s = {16'd0, key_r[79:64]};
      A_STATUS: rd_data_s = {30'd0, done_r, busy_r};
      A_PT_LO:  rd_data_s = pt_r[31:0];
      A_PT_HI:  rd_data_s = pt_r[63:32];
      default:  rd_data_s = 32'd0;
    endcase
  end

  // odat updates only on a read strobe and otherwise holds.
  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset) begin
      odat_r <= 32'd0;
    end else if (rd_s) begin
      odat_r <= rd_data_s;
    end else begin
      odat_r <= odat_r;
    end
  end

endmodule

// File: tb/tb_present_dec_wrapper.sv
// Scoreboarded bench for present_dec_wrapper: reads push expectations, a monitor pops them.
module tb_present_dec_wrapper;

  logic        clk = 1'b0;
  logic        iReset;
  logic        iChipselect;
  logic        iWriteRead;
  logic [3:0]  iAddress;
  logic [31:0] idat;
  logic [31:0] odat;

  present_dec_wrapper dut (
    .clk(clk), .iReset(iReset), .iChipselect(iChipselect), .iWriteRead(iWriteRead),
    .iAddress(iAddress), .idat(idat), .odat(odat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference cipher (textbook PRESENT-80) ----------------
  logic [3:0] sb  [16];
  logic [3:0] isb [16];

  function automatic logic [79:0] ks_next(logic [79:0] k, int r);
    logic [79:0] t;
    t = {k[18:0], k[79:19]};
    t[79:76] = sb[t[79:76]];
    t[19:15] = t[19:15] ^ 5'(r);
    return t;
  endfunction

  function automatic logic [63:0] sub_layer(logic [63:0] s, bit inv);
    logic [63:0] o;
    logic [3:0] nib;
    o = 64'd0;
    for (int n = 0; n < 16; n++) begin
      nib = s[n*4 +: 4];
      o[n*4 +: 4] = inv ? isb[nib] : sb[nib];
    end
    return o;
  endfunction

  function automatic logic [63:0] perm(logic [63:0] s, bit inv);
    logic [63:0] o;
    int pi;
    o = 64'd0;
    for (int i = 0; i < 64; i++) begin
      pi = (i == 63) ? 63 : (16 * i) % 63;
      if (inv) o[i] = s[pi];
      else     o[pi] = s[i];
    end
    return o;
  endfunction

  function automatic logic [63:0] ref_encrypt(logic [63:0] p, logic [79:0] key);
    logic [79:0] k;
    logic [63:0] s;
    k = key;
    s = p;
    for (int r = 1; r <= 31; r++) begin
      s = perm(sub_layer(s ^ k[79:16], 1'b0), 1'b0);
      k = ks_next(k, r);
    end
    return s ^ k[79:16];
  endfunction

  function automatic logic [63:0] ref_decrypt(logic [63:0] c, logic [79:0] key);
    logic [63:0] rk [1:32];
    logic [79:0] k;
    logic [63:0] s;
    k = key;
    rk[1] = k[79:16];
    for (int r = 1; r <= 31; r++) begin
      k = ks_next(k, r);
      rk[r+1] = k[79:16];
    end
    s = c ^ rk[32];
    for (int r = 31; r >= 1; r--) begin
      s = sub_layer(perm(s, 1'b1), 1'b1) ^ rk[r];
    end
    return s;
  endfunction

  // ---------------- register-level model ----------------
  logic [63:0] m_ct;
  logic [79:0] m_key;
  logic [63:0] m_pt_prev;
  logic [63:0] m_pt_res;
  bit          m_has_run;
  int          m_e0;

  function automatic bit m_busy();
    return m_has_run && (cyc < m_e0 + 63);
  endfunction

  function automatic bit m_done();
    return m_has_run && (cyc >= m_e0 + 63);
  endfunction

  function automatic logic [63:0] m_pt();
    return m_done() ? m_pt_res : m_pt_prev;
  endfunction

  function automatic logic [31:0] exp_read(logic [3:0] a);
    logic [63:0] p;
    p = m_pt();
    case (a)
      4'h0:    return m_ct[31:0];
      4'h1:    return m_ct[63:32];
      4'h2:    return m_key[31:0];
      4'h3:    return m_key[63:32];
      4'h4:    return {16'd0, m_key[79:64]};
      4'h6:    return {30'd0, m_done(), m_busy()};
      4'h8:    return p[31:0];
      4'h9:    return p[63:32];
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_ct = 64'd0; m_key = 80'd0; m_pt_prev = 64'd0; m_pt_res = 64'd0;
    m_has_run = 1'b0; m_e0 = 0;
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q  [$];
  logic [3:0]  addr_q [$];
  logic        rd_q;

  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset) rd_q <= 1'b0;
    else         rd_q <= iChipselect & ~iWriteRead;
  end

  always @(negedge clk) begin
    if (rd_q) begin
      logic [31:0] e;
      logic [3:0]  a;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL rd_unexpected got %08h required no read", odat);
      end else begin
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        if (odat !== e) begin
          n_errors++;
          $display("FAIL rd_addr_%0h at cyc %0d got %08h required %08h", a, cyc, odat, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_write(logic [3:0] a, logic [31:0] d);
    @(negedge clk);
    iChipselect = 1'b1; iWriteRead = 1'b1; iAddress = a; idat = d;
    case (a)
      4'h0: m_ct[31:0]   = d;
      4'h1: m_ct[63:32]  = d;
      4'h2: m_key[31:0]  = d;
      4'h3: m_key[63:32] = d;
      4'h4: m_key[79:64] = d[15:0];
      4'h5: if (d[0] && !m_busy()) begin
              m_pt_prev = m_pt();
              m_e0      = cyc + 1;
              m_pt_res  = ref_decrypt(m_ct, m_key);
              m_has_run = 1'b1;
            end
      default: ;
    endcase
  endtask

  task automatic do_read(logic [3:0] a);
    @(negedge clk);
    iChipselect = 1'b1; iWriteRead = 1'b0; iAddress = a; idat = $urandom();
    exp_q.push_back(exp_read(a));
    addr_q.push_back(a);
  endtask

  task automatic do_read_const(logic [3:0] a, logic [31:0] e);
    @(negedge clk);
    iChipselect = 1'b1; iWriteRead = 1'b0; iAddress = a; idat = 32'd0;
    exp_q.push_back(e);
    addr_q.push_back(a);
  endtask

  task automatic do_idle(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      iChipselect = 1'b0; iWriteRead = 1'b0; iAddress = 4'h0; idat = 32'd0;
    end
  endtask

  task automatic load(logic [79:0] key, logic [63:0] ct);
    logic [79:0] k;
    logic [63:0] c;
    k = key;
    c = ct;
    do_write(4'h2, k[31:0]);
    do_write(4'h3, k[63:32]);
    do_write(4'h4, {16'd0, k[79:64]});
    do_write(4'h0, c[31:0]);
    do_write(4'h1, c[63:32]);
  endtask

  task automatic poll(int n);
    for (int i = 0; i < n; i++) do_read(4'h6);
  endtask

  task automatic expect_pt(logic [63:0] p);
    logic [63:0] v;
    v = p;
    do_read_const(4'h8, v[31:0]);
    do_read_const(4'h9, v[63:32]);
  endtask

  initial begin
    logic [31:0] r0, r1, r2, r3, r4;
    logic [79:0] rkey;
    logic [63:0] rpt;
    sb = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    for (int i = 0; i < 16; i++) isb[sb[i]] = 4'(i);
    model_reset();
    iReset = 1'b0; iChipselect = 1'b0; iWriteRead = 1'b0; iAddress = 4'h0; idat = 32'd0;
    do_idle(3);
    iReset = 1'b1;

    // reset state of every address
    for (int a = 0; a < 10; a++) do_read(4'(a));

    // unmapped reads and the 16-bit top key word
    do_read(4'h7); do_read(4'hA); do_read(4'hF);
    do_write(4'h4, 32'hABCD1234);
    do_read_const(4'h4, 32'h0000_1234);
    do_write(4'h5, 32'h0000_0000);
    do_read_const(4'h6, 32'h0);

    // KAT: zero key
    load(80'd0, 64'h5579C1387B228445);
    do_write(4'h5, 32'h1);
    poll(66);
    do_read_const(4'h6, 32'h2);
    expect_pt(64'h0);

    // KAT: all-ones key, then restart with second ciphertext
    load({80{1'b1}}, 64'hE72C46C0F5945049);
    do_write(4'h5, 32'h1);
    poll(65);
    expect_pt(64'h0);
    do_write(4'h0, 32'h213210D2);
    do_write(4'h1, 32'h3333DCD3);
    do_write(4'h5, 32'h1);
    poll(65);
    expect_pt(64'hFFFF_FFFF_FFFF_FFFF);

    // inputs rewritten and start reissued mid-run
    load(80'd0, 64'hA112FFC72F68417B);
    do_write(4'h5, 32'h1);
    poll(9);
    do_write(4'h0, 32'h0);
    do_write(4'h1, 32'h0);
    do_write(4'h5, 32'h1);
    poll(3);
    expect_pt(64'hFFFF_FFFF_FFFF_FFFF);
    poll(50);
    expect_pt(64'hFFFF_FFFF_FFFF_FFFF);
    do_read_const(4'h0, 32'h0);

    // reset during a run
    load(80'h1234_5678_9ABC_DEF0_1357, 64'h0123_4567_89AB_CDEF);
    do_write(4'h5, 32'h1);
    poll(18);
    do_idle(1);
    @(negedge clk);
    iReset = 1'b0;
    #1;
    n_checks++;
    if (odat !== 32'd0) begin
      n_errors++;
      $display("FAIL odat_in_reset got %08h required 00000000", odat);
    end
    model_reset();
    do_idle(2);
    iReset = 1'b1;
    do_read_const(4'h8, 32'h0);
    do_read_const(4'h9, 32'h0);
    do_read_const(4'h0, 32'h0);
    do_read_const(4'h6, 32'h0);

    // random round trips through the reference encryptor
    for (int t = 0; t < 100; t++) begin
      r0 = $urandom(); r1 = $urandom(); r2 = $urandom(); r3 = $urandom(); r4 = $urandom();
      rkey = {r0[15:0], r1, r2};
      rpt  = {r3, r4};
      load(rkey, ref_encrypt(rpt, rkey));
      do_write(4'h5, 32'h1);
      poll(64);
      expect_pt(rpt);
    end

    do_idle(3);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
